// File: rtl/cc_stream.sv
// rtl/cc_stream.sv - streaming four-operand compute core: collect, sort, mean-remove, evaluate
// Operands are held at 6 bits so mean-removed values (range -15..15) never overflow.
module cc_stream (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic [2:0] in_opt,
    output logic       in_ready,
    output logic       out_valid,
    output logic [8:0] out_data,
    input  logic       out_ready
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_COLLECT,
        S_SORT0,
        S_SORT1,
        S_SORT2,
        S_SORT3,
        S_MEAN,
        S_CALC,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [2:0]         opt_q, opt_d;
    logic signed [5:0]  n_q [4];
    logic signed [5:0]  n_d [4];
    logic [8:0]         res_q, res_d;

    logic               accept;
    logic signed [5:0]  din_w;
    logic signed [5:0]  sum_w;
    logic signed [5:0]  adj_w;
    logic signed [5:0]  mean_w;
    logic signed [11:0] e0, e1, e2, e3;
    logic signed [11:0] prod_a, prod_b, calc_w;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = res_q;
    assign accept    = in_valid && in_ready;
    assign din_w     = {{2{in_data[3]}}, in_data};

    // Arithmetic shift floors; biasing negative sums by 3 turns it into truncation toward zero.
    assign sum_w  = n_q[0] + n_q[1] + n_q[2] + n_q[3];
    assign adj_w  = sum_w + (sum_w[5] ? 6'sd3 : 6'sd0);
    assign mean_w = adj_w >>> 2;

    assign e0 = {{6{n_q[0][5]}}, n_q[0]};
    assign e1 = {{6{n_q[1][5]}}, n_q[1]};
    assign e2 = {{6{n_q[2][5]}}, n_q[2]};
    assign e3 = {{6{n_q[3][5]}}, n_q[3]};

    assign prod_a = (e3 + e2) * e1;
    assign prod_b = ((e1 * e0) <<< 1) + e3;
    assign calc_w = opt_q[2] ? prod_b : prod_a;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opt_d   = opt_q;
        n_d     = n_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    n_d[0]  = din_w;
                    opt_d   = in_opt;
                    cnt_d   = 2'd1;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    n_d[cnt_q] = din_w;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_SORT0;
                    end
                end
            end
            S_SORT0, S_SORT2: begin
                if (opt_q[0] && (n_q[0] < n_q[1])) begin
                    n_d[0] = n_q[1];
                    n_d[1] = n_q[0];
                end
                if (opt_q[0] && (n_q[2] < n_q[3])) begin
                    n_d[2] = n_q[3];
                    n_d[3] = n_q[2];
                end
                state_d = (state_q == S_SORT0) ? S_SORT1 : S_SORT3;
            end
            S_SORT1, S_SORT3: begin
                if (opt_q[0] && (n_q[1] < n_q[2])) begin
                    n_d[1] = n_q[2];
                    n_d[2] = n_q[1];
                end
                state_d = (state_q == S_SORT1) ? S_SORT2 : S_MEAN;
            end
            S_MEAN: begin
                if (opt_q[1]) begin
                    for (int i = 0; i < 4; i++) begin
                        n_d[i] = n_q[i] - mean_w;
                    end
                end
                state_d = S_CALC;
            end
            S_CALC: begin
                res_d   = calc_w[8:0];
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            opt_q   <= 3'd0;
            res_q   <= 9'd0;
            for (int i = 0; i < 4; i++) begin
                n_q[i] <= 6'sd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opt_q   <= opt_d;
            res_q   <= res_d;
            n_q     <= n_d;
        end
    end

endmodule

// File: tb/tb_cc_stream.sv
// tb/tb_cc_stream.sv - directed self-checking bench for cc_stream
module tb_cc_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic [2:0] in_opt;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_ready;

    int checks;
    int errors;

    cc_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_opt    (in_opt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input int d, input logic [2:0] o);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'(d);
        in_opt   = o;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] o, input int a, input int b,
                              input int c, input int d, input int gap);
        int v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            send_beat(v[k], o);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    task automatic get_result(input int expv, input string name);
        int t;
        logic [8:0] e;
        e = 9'(expv);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout out_valid=%b required=1", name, out_valid);
        end
        checks++;
        if (out_data !== e) begin
            errors++;
            $display("FAIL %s_data out_data=%0d required=%0d", name, $signed(out_data), $signed(e));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_handshake in_ready=%b out_valid=%b required 1,0", name, in_ready, out_valid);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 9'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid=%b out_data=%0d in_ready=%b required 0,0,1",
                     name, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_state");
    endtask

    task automatic test_passthrough_latency();
        send_frame(3'b000, 3, 2, 1, 4, 0);
        // We are just past edge 1 (beat 3 accepted); result must appear after edge 7.
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL latency_edge%0d out_valid=%b in_ready=%b required 0,0", k, out_valid, in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 9'd10) begin
            errors++;
            $display("FAIL latency_out out_valid=%b out_data=%0d required 1,10", out_valid, $signed(out_data));
        end
        get_result(10, "passthrough");
    endtask

    task automatic test_sort();
        send_frame(3'b001, 3, -2, 5, 0, 0);
        get_result(-6, "sort");
    endtask

    task automatic test_mean();
        send_frame(3'b010, 1, 2, 3, 6, 0);
        get_result(-3, "mean");
        send_frame(3'b110, -1, -1, -1, -2, 0);
        get_result(-1, "mean_neg_trunc");
    endtask

    task automatic test_full_path();
        send_frame(3'b111, -8, -7, -6, 5, 0);
        get_result(-40, "full_path");
    endtask

    task automatic test_gaps();
        send_frame(3'b111, -8, -7, -6, 5, 2);
        get_result(-40, "gaps");
        send_frame(3'b001, 3, -2, 5, 0, 2);
        get_result(-6, "gaps_sort");
    endtask

    task automatic test_backpressure();
        logic [8:0] held;
        int t;
        send_frame(3'b010, 1, 2, 3, 6, 0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_data  = 4'(k);
            in_opt   = 3'b111;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 9'h1FD) begin
                errors++;
                $display("FAIL backpressure_hold%0d out_valid=%b in_ready=%b out_data=%0d required 1,0,-3",
                         k, out_valid, in_ready, $signed(out_data));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_data !== held) begin
            errors++;
            $display("FAIL backpressure_stable out_data=%0d required=%0d", $signed(out_data), $signed(held));
        end
        get_result(-3, "backpressure");
        // The beats toggled during OUT must not have leaked into this frame.
        send_frame(3'b000, 3, 2, 1, 4, 0);
        get_result(10, "after_backpressure");
    endtask

    task automatic test_reset_mid();
        send_beat(7, 3'b111);
        send_beat(7, 3'b111);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_collect");
        send_frame(3'b000, 3, 2, 1, 4, 0);
        get_result(10, "after_reset_collect");

        send_frame(3'b111, -8, -7, -6, 5, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_sort");
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_sort_no_result%0d out_valid=%b in_ready=%b required 0,1", k, out_valid, in_ready);
            end
        end
        send_frame(3'b001, 3, -2, 5, 0, 0);
        get_result(-6, "after_reset_sort");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_opt    = 3'd0;
        out_ready = 1'b0;
        test_reset();
        test_passthrough_latency();
        test_sort();
        test_mean();
        test_full_path();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
